audiodac_ctrl: RTL
==================

// Module: audiodac_ctrl
// PURPOSE
//  Sequencer/feeder for the audio delta-sigma modulator. Buffers host samples in a small FIFO
//  and serves them on each modulator fetch strobe. Owns modulator reset, mode/OSR configuration
//  and the scale setting, so start/stop are click-free soft ramps in 6 dB steps.
// PARAMETERS
//  BW          16  sample width (UINT, midscale 1<<(BW-1))
//  FIFO_DEPTH  8   sample FIFO entries, power of 2, >=2
//  RAMP_LOG2   4   one 6 dB scale step per 2^RAMP_LOG2 fetch strobes
// PORTS
//  clk_i         in   1               system/modulator clock
//  rst_i         in   1               asynchronous reset, active-high
//  enable_i      in   1               level: 1=play, 0=stop (ramped)
//  mode_cfg_i    in   1               requested modulator order (0=1st, 1=2nd)
//  osr_cfg_i     in   2               requested OSR code (0=32..3=256)
//  vol_i         in   4               target scale (0=0 dB .. 15=off)
//  s_data_i      in   BW              host sample
//  s_valid_i     in   1               host sample valid
//  s_ready_o     out  1               FIFO can accept (=!full)
//  data_o        out  BW              sample to modulator data input, registered
//  data_rd_i     in   1               modulator fetch strobe (1 cycle per OSR cycles)
//  mod_rst_n_o   out  1               modulator sync reset, active-low, registered
//  mode_o        out  1               modulator mode, registered
//  osr_o         out  2               modulator OSR code, registered
//  scale_o       out  4               modulator scale, registered
//  busy_o        out  1               state != IDLE
//  fifo_level_o  out  log2(DEPTH)+1   FIFO occupancy
//  uflow_o       out  1               1-cycle pulse: fetch served from empty FIFO
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, data_o=MID, mod_rst_n_o=0, scale_o=15,
//   mode_o=0, osr_o=0, uflow_o=0, ramp counter=0; s_ready_o=1 once FIFO empty.
//  FSM IDLE -> START -> RAMP_UP -> RUN -> RAMP_DOWN -> IDLE:
//   IDLE: mod_rst_n_o=0, scale_o=15, data_o=MID; mode_o/osr_o copy cfg inputs each cycle.
//     enable_i & level>0 -> START.
//   START: mod_rst_n_o=1. mode_o/osr_o frozen until the next IDLE. First data_rd_i -> RAMP_UP.
//   RAMP_UP: ramp counter counts data_rd_i. On wrap: scale_o-1. At scale_o==vol_i -> RUN.
//     vol_i==15 -> RUN immediately.
//   RUN: on each counter wrap, scale_o steps one toward vol_i (up or down).
//   enable_i=0 in START/RAMP_UP/RUN -> RAMP_DOWN. START->RAMP_DOWN with scale 15 -> IDLE next cycle.
//   RAMP_DOWN: on each wrap, scale_o+1. Reaching 15 -> IDLE.
//     enable_i=1 in RAMP_DOWN -> RAMP_UP from current scale_o. Counter is not cleared.
//  Ramp counter is RAMP_LOG2 bits. It advances only on data_rd_i and clears on entry to START.
//  Sample path, on data_rd_i in any state except IDLE:
//   - level>0: pop; data_o<=head (1-cycle latency).
//   - level==0: data_o<=MID; uflow_o=1 next cycle.
//   data_o holds between strobes. data_rd_i in IDLE is ignored.
//  FIFO: push = s_valid_i & s_ready_o.
//   - Push and pop in the same cycle: level unchanged.
//   - Push into empty FIFO in the same cycle as data_rd_i: underflow. No bypass; the sample stays queued.
//   - FIFO is not flushed on IDLE; it is emptied only by pops or rst_i.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Mid-operation rst_i: immediate IDLE values; modulator held in reset.
// CONFIGURATION
//  `AUDIODAC_CTRL_UFLOW_CNT_EN` defined:
//   - adds port uflow_cnt_o (out, 8): saturating count of uflow_o pulses;
//   - cleared on IDLE->START and on rst_i; holds at 255.
//  Not defined: port and counter absent; uflow_o unchanged.
// STRUCTURE
//  audiodac_pkg.vh: FSM state localparams (3b), DATA_MID, SCALE_OFF=15, OSR/MODE codes
//   (shared with the modulator).
//  Sub-module audiodac_fifo (BW, FIFO_DEPTH):
//   - sync FIFO, push/pop/full/empty/level, registered head;
//   - instantiated once; FSM and ramp logic stay in this module.
// TESTING
//  1) rst_i pulse mid-RUN -> same cycle mod_rst_n_o=0, scale_o=15, data_o=16'h8000, busy_o=0.
//  2) RAMP_LOG2=2, vol_i=3, preload 4 samples, enable_i=1
//     -> scale_o 15,14..3 one step per 4 data_rd_i; then RUN; samples emitted in order.
//  3) Empty FIFO in RUN, data_rd_i -> data_o=16'h8000, uflow_o pulse. With _EN: uflow_cnt_o 0->1.
//     256 underflows -> saturates at 255.
//  4) Fill 8 samples -> s_ready_o=0, level=8. Push+pop same cycle at level 4 -> level stays 4.
//  5) enable_i=0 at scale 3 -> RAMP_DOWN to 15 (12 steps), IDLE, mod_rst_n_o=0.
//     Re-enable at scale 9 -> RAMP_UP from 9.
//  6) osr_cfg_i changed 1->3 in RUN -> osr_o stays 1. After IDLE -> osr_o=3.

Source files
------------

// File: rtl/audiodac_pkg.sv
// Shared definitions for the audio DAC controller and the delta-sigma modulator:
// sequencer state codes, scale limits and modulator mode/OSR codes.
package audiodac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } state_e;

    typedef enum logic {
        MODE_1ST = 1'b0,
        MODE_2ND = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        OSR_32  = 2'd0,
        OSR_64  = 2'd1,
        OSR_128 = 2'd2,
        OSR_256 = 2'd3
    } osr_e;

    localparam int unsigned SCALE_W   = 4;
    localparam logic [3:0]  SCALE_OFF = 4'd15;

endpackage

// File: rtl/audiodac_fifo.sv
// Synchronous sample FIFO; head reads straight from storage at the read pointer.
module audiodac_fifo #(
    parameter int unsigned BW         = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push,
    input  logic [BW-1:0]                 wdata,
    input  logic                          pop,
    output logic [BW-1:0]                 head_c,
    output logic                          full_c,
    output logic                          empty_c,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [BW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head_c  = mem[rd_ptr];
    assign full_c  = (level == LW'(FIFO_DEPTH));
    assign empty_c = (level == '0);

endmodule

// File: rtl/audiodac_ctrl.sv
// Sequencer/feeder for the audio delta-sigma modulator with click-free soft start/stop.
// Define AUDIODAC_CTRL_UFLOW_CNT_EN to add the saturating underflow counter port uflow_cnt_o.
module audiodac_ctrl
    import audiodac_pkg::*;
#(
    parameter int unsigned BW         = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RAMP_LOG2  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          mode_cfg_i,
    input  logic [1:0]                    osr_cfg_i,
    input  logic [3:0]                    vol_i,
    input  logic [BW-1:0]                 s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [BW-1:0]                 data_o,
    input  logic                          data_rd_i,
    output logic                          mod_rst_n_o,
    output logic                          mode_o,
    output logic [1:0]                    osr_o,
    output logic [3:0]                    scale_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
`ifdef AUDIODAC_CTRL_UFLOW_CNT_EN
    output logic [7:0]                    uflow_cnt_o,
`endif
    output logic                          uflow_o
);

    localparam logic [BW-1:0] DATA_MID = {1'b1, {(BW-1){1'b0}}};

    state_e               state_q;
    state_e               state_d;
    logic [SCALE_W-1:0]   scale_d;
    logic [RAMP_LOG2-1:0] ramp_cnt_q;

    logic          fifo_full_c;
    logic          fifo_empty_c;
    logic [BW-1:0] fifo_head_c;
    logic          push_c;
    logic          pop_c;
    logic          fetch_c;
    logic          wrap_c;
    logic          start_c;

    assign s_ready_o = !fifo_full_c;
    assign push_c    = s_valid_i && s_ready_o;
    assign fetch_c   = data_rd_i && (state_q != ST_IDLE);
    assign pop_c     = fetch_c && !fifo_empty_c;
    assign wrap_c    = fetch_c && (ramp_cnt_q == {RAMP_LOG2{1'b1}});
    assign start_c   = (state_q == ST_IDLE) && (state_d == ST_START);

    audiodac_fifo #(
        .BW         (BW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push_c),
        .wdata   (s_data_i),
        .pop     (pop_c),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .level   (fifo_level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and next scale; a scale step only happens on a ramp-counter wrap.
    always_comb begin
        state_d = state_q;
        scale_d = scale_o;
        case (state_q)
            ST_IDLE: begin
                scale_d = SCALE_OFF;
                if (enable_i && !fifo_empty_c) state_d = ST_START;
            end
            ST_START: begin
                if (!enable_i)      state_d = ST_RAMP_DOWN;
                else if (data_rd_i) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (!enable_i)              state_d = ST_RAMP_DOWN;
                else if (scale_o <= vol_i)  state_d = ST_RUN;
                else if (wrap_c)            scale_d = scale_o - 4'd1;
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_RAMP_DOWN;
                if (wrap_c) begin
                    if (scale_o < vol_i)      scale_d = scale_o + 4'd1;
                    else if (scale_o > vol_i) scale_d = scale_o - 4'd1;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable_i)                  state_d = ST_RAMP_UP;
                else if (scale_o == SCALE_OFF) state_d = ST_IDLE;
                else if (wrap_c)               scale_d = scale_o + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered modulator interface; config tracks inputs only while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ramp_cnt_q  <= '0;
            data_o      <= DATA_MID;
            mod_rst_n_o <= 1'b0;
            busy_o      <= 1'b0;
            scale_o     <= SCALE_OFF;
            mode_o      <= MODE_1ST;
            osr_o       <= OSR_32;
            uflow_o     <= 1'b0;
        end else begin
            mod_rst_n_o <= (state_d != ST_IDLE);
            busy_o      <= (state_d != ST_IDLE);
            scale_o     <= scale_d;
            uflow_o     <= fetch_c && fifo_empty_c;
            if (start_c)      ramp_cnt_q <= '0;
            else if (fetch_c) ramp_cnt_q <= ramp_cnt_q + RAMP_LOG2'(1);
            if (state_q == ST_IDLE) begin
                mode_o <= mode_cfg_i;
                osr_o  <= osr_cfg_i;
                data_o <= DATA_MID;
            end else if (fetch_c) begin
                data_o <= fifo_empty_c ? DATA_MID : fifo_head_c;
            end
        end
    end

`ifdef AUDIODAC_CTRL_UFLOW_CNT_EN
    // Underflow count per play session, saturating at 255.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                            uflow_cnt_o <= '0;
        else if (start_c)                                     uflow_cnt_o <= '0;
        else if (fetch_c && fifo_empty_c && uflow_cnt_o != 8'hFF) uflow_cnt_o <= uflow_cnt_o + 8'd1;
    end
`endif

endmodule
